bcd_pipeline_converter: RTL and testbench

Parametrised, fully pipelined binary-to-BCD converter with a valid/ready handshake, optional two's-complement input, saturation on digit overflow and leading-zero blanking. It is the next-generation converter feeding the display/readout path: one add-3/shift stage per input bit, one sample per cycle, and backpressure from the display formatter.

---
 rtl/bcd_pipeline_converter_pkg.sv | 13 +
 rtl/bcd_pipeline_converter_if.sv | 30 +++
 rtl/bcd_pipeline_converter_shift_stage.sv | 59 +++++
 rtl/bcd_pipeline_converter.sv | 131 +++++++++++++
 tb/tb_bcd_pipeline_converter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pipeline_converter_pkg.sv
// Shared types and helpers for the binary-to-BCD pipeline.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BLANK_DIGIT = 4'hF;

    // Decimal digits needed to hold any n-bit unsigned value (1233/4096 ~ log10(2)).
    function automatic int bcd_digits_for(input int n);
        return ((n * 1233) >> 12) + 1;
    endfunction

endpackage

// File: rtl/bcd_pipeline_converter_if.sv
// Sample-in / result-out handshake bundle of the BCD converter.
interface bcd_pipeline_converter_if
    import bcd_pkg::*;
#(
    parameter int DATA_IN_BITS = 12,
    parameter int DIGITS       = 4
) ();

    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_IN_BITS-1:0]      data_in;
    logic                         blank_en;
    logic                         out_valid;
    logic                         out_ready;
    bcd_digit_t                   digits_out [DIGITS];
    logic                         sign_out;
    logic                         overflow_out;
    logic [$clog2(DIGITS+1)-1:0]  num_digits_out;

    modport master (
        output in_valid, data_in, blank_en, out_ready,
        input  in_ready, out_valid, digits_out, sign_out, overflow_out, num_digits_out
    );

    modport slave (
        input  in_valid, data_in, blank_en, out_ready,
        output in_ready, out_valid, digits_out, sign_out, overflow_out, num_digits_out
    );

endinterface

// File: rtl/bcd_pipeline_converter_shift_stage.sv
// One double-dabble step: add-3 correction then shift one magnitude bit into the BCD field.
module bcd_shift_stage
    import bcd_pkg::*;
#(
    parameter int DATA_IN_BITS = 12,
    parameter int INT_DIGITS   = 4,
    parameter int STAGE        = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         vld,
    input  logic                         sign,
    input  logic                         blank,
    input  logic [INT_DIGITS-1:0][3:0]   bcd,
    input  logic [DATA_IN_BITS-1:0]      bin,
    output logic                         vld_q,
    output logic                         sign_q,
    output logic                         blank_q,
    output logic [INT_DIGITS-1:0][3:0]   bcd_q,
    output logic [DATA_IN_BITS-1:0]      bin_q
);

    // STAGE bits have been shifted in so far, so digits above this count are still zero
    // and need no correction logic.
    localparam int NEED   = (STAGE == 0) ? 0 : bcd_digits_for(STAGE);
    localparam int ACTIVE = (NEED > INT_DIGITS) ? INT_DIGITS : NEED;
    localparam int VW     = INT_DIGITS * 4 + DATA_IN_BITS;

    logic [INT_DIGITS-1:0][3:0] adj;
    logic [VW-1:0]              shifted;

    // Correct every digit >= 5, then shift the whole {BCD, remaining bits} vector.
    always_comb begin
        for (int j = 0; j < INT_DIGITS; j++) begin
            if (j < ACTIVE && bcd[j] >= 4'd5) adj[j] = bcd[j] + 4'd3;
            else                              adj[j] = bcd[j];
        end
        shifted = {adj, bin} << 1;
    end

    // Stage register; holds everything, including valid, while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            sign_q  <= 1'b0;
            blank_q <= 1'b0;
            bcd_q   <= '0;
            bin_q   <= '0;
        end else if (en) begin
            vld_q   <= vld;
            sign_q  <= sign;
            blank_q <= blank;
            bcd_q   <= shifted[VW-1:DATA_IN_BITS];
            bin_q   <= shifted[DATA_IN_BITS-1:0];
        end
    end

endmodule

// File: rtl/bcd_pipeline_converter.sv
// Fully pipelined binary-to-BCD converter: capture, one shift stage per bit, output formatting.
module bcd_pipeline_converter
    import bcd_pkg::*;
#(
    parameter int DATA_IN_BITS = 12,
    parameter int DIGITS       = 4,
    parameter int SIGNED       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_pipeline_converter_if.slave bus
);

    localparam int STAGES     = DATA_IN_BITS;
    localparam int INT_DIGITS = bcd_digits_for(DATA_IN_BITS);
    localparam int WD         = (DIGITS > INT_DIGITS) ? DIGITS : INT_DIGITS;
    localparam int NDW        = $clog2(DIGITS + 1);

    logic                        stall;
    logic                        en;
    logic                        neg;
    logic [DATA_IN_BITS-1:0]     mag;
    logic                        s0_vld, s0_sign, s0_blank;
    logic [DATA_IN_BITS-1:0]     s0_mag;

    logic [STAGES:0]             vld_pipe, sign_pipe, blank_pipe;
    logic [DATA_IN_BITS-1:0]     bin_pipe [STAGES+1];
    logic [INT_DIGITS-1:0][3:0]  bcd_pipe [STAGES+1];

    logic [WD-1:0][3:0]          ext;
    logic [DIGITS-1:0][3:0]      dig;
    logic                        ovf;
    logic                        seen;
    logic [NDW-1:0]              nd;
    logic                        unused_tail;

    // The only combinational path: a held result stops the whole pipe and the input.
    assign stall        = bus.out_valid && !bus.out_ready;
    assign en           = !stall;
    assign bus.in_ready = !rst && !stall;

    // Unary minus at full width maps -2^(N-1) onto 2^(N-1) as an unsigned magnitude.
    assign neg = (SIGNED != 0) && bus.data_in[DATA_IN_BITS-1];
    assign mag = neg ? -bus.data_in : bus.data_in;

    // S0 capture of magnitude and sidebands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld   <= 1'b0;
            s0_sign  <= 1'b0;
            s0_blank <= 1'b0;
            s0_mag   <= '0;
        end else if (en) begin
            s0_vld   <= bus.in_valid;
            s0_sign  <= neg;
            s0_blank <= bus.blank_en;
            s0_mag   <= mag;
        end
    end

    assign vld_pipe[0]   = s0_vld;
    assign sign_pipe[0]  = s0_sign;
    assign blank_pipe[0] = s0_blank;
    assign bin_pipe[0]   = s0_mag;
    assign bcd_pipe[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        bcd_shift_stage #(
            .DATA_IN_BITS (DATA_IN_BITS),
            .INT_DIGITS   (INT_DIGITS),
            .STAGE        (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .vld     (vld_pipe[k]),
            .sign    (sign_pipe[k]),
            .blank   (blank_pipe[k]),
            .bcd     (bcd_pipe[k]),
            .bin     (bin_pipe[k]),
            .vld_q   (vld_pipe[k+1]),
            .sign_q  (sign_pipe[k+1]),
            .blank_q (blank_pipe[k+1]),
            .bcd_q   (bcd_pipe[k+1]),
            .bin_q   (bin_pipe[k+1])
        );
    end

    // Every magnitude bit has been shifted out by now; the tail is all zeros.
    assign unused_tail = ^bin_pipe[STAGES];

    // Saturate on overflow, count significant digits, blank leading zeros above the top digit.
    always_comb begin
        ext = (WD*4)'(bcd_pipe[STAGES]);
        ovf = 1'b0;
        for (int j = DIGITS; j < WD; j++)
            if (ext[j] != 4'd0) ovf = 1'b1;
        nd = NDW'(1);
        for (int j = 1; j < DIGITS; j++)
            if (ext[j] != 4'd0) nd = NDW'(j + 1);
        seen = 1'b0;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            if (ovf)
                dig[j] = 4'd9;
            else if (blank_pipe[STAGES] && !seen && j != 0 && ext[j] == 4'd0)
                dig[j] = BLANK_DIGIT;
            else
                dig[j] = ext[j];
            if (ext[j] != 4'd0) seen = 1'b1;
        end
        if (ovf) nd = NDW'(DIGITS);
    end

    // Output register; stable while the consumer holds off.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.sign_out       <= 1'b0;
            bus.overflow_out   <= 1'b0;
            bus.num_digits_out <= '0;
            for (int i = 0; i < DIGITS; i++) bus.digits_out[i] <= '0;
        end else if (en) begin
            bus.out_valid      <= vld_pipe[STAGES];
            bus.sign_out       <= sign_pipe[STAGES];
            bus.overflow_out   <= ovf;
            bus.num_digits_out <= nd;
            for (int i = 0; i < DIGITS; i++) bus.digits_out[i] <= dig[i];
        end
    end

endmodule

// File: tb/tb_bcd_pipeline_converter.sv
// Bench for the BCD converter: three configurations share one stimulus stream and are
// each checked against a decimal-arithmetic model.
module tb_bcd_pipeline_converter;
    import bcd_pkg::*;

    localparam int W = 12;
    localparam int SG [3] = '{0, 1, 0};
    localparam int DG [3] = '{4, 4, 3};

    typedef struct packed {
        logic        vld;
        logic [15:0] dg;
        logic        sg;
        logic        ov;
        logic [3:0]  nd;
    } obs_t;

    typedef struct packed {
        logic [W-1:0] v;
        logic         b;
    } in_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         blank_en = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] data_in = '0;
    bit           rnd_mode = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;

    obs_t obs [3];
    logic irdy [3];
    in_t  q [3][$];
    obs_t prev_obs [3];
    bit   prev_stall [3];

    always #5 clk = ~clk;

    bcd_pipeline_converter_if #(.DATA_IN_BITS(W), .DIGITS(4)) if0 ();
    bcd_pipeline_converter_if #(.DATA_IN_BITS(W), .DIGITS(4)) if1 ();
    bcd_pipeline_converter_if #(.DATA_IN_BITS(W), .DIGITS(3)) if2 ();

    assign if0.in_valid = in_valid;  assign if0.data_in = data_in;
    assign if0.blank_en = blank_en;  assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.data_in = data_in;
    assign if1.blank_en = blank_en;  assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.data_in = data_in;
    assign if2.blank_en = blank_en;  assign if2.out_ready = out_ready;

    bcd_pipeline_converter #(.DATA_IN_BITS(W), .DIGITS(4), .SIGNED(0)) u_def (.clk(clk), .rst(rst), .bus(if0.slave));
    bcd_pipeline_converter #(.DATA_IN_BITS(W), .DIGITS(4), .SIGNED(1)) u_sgn (.clk(clk), .rst(rst), .bus(if1.slave));
    bcd_pipeline_converter #(.DATA_IN_BITS(W), .DIGITS(3), .SIGNED(0)) u_d3  (.clk(clk), .rst(rst), .bus(if2.slave));

    // Flatten each DUT's outputs into a common 4-digit view.
    always_comb begin
        for (int k = 0; k < 3; k++) obs[k] = '0;
        obs[0].vld = if0.out_valid; obs[0].sg = if0.sign_out; obs[0].ov = if0.overflow_out;
        obs[0].nd  = 4'(if0.num_digits_out);
        obs[1].vld = if1.out_valid; obs[1].sg = if1.sign_out; obs[1].ov = if1.overflow_out;
        obs[1].nd  = 4'(if1.num_digits_out);
        obs[2].vld = if2.out_valid; obs[2].sg = if2.sign_out; obs[2].ov = if2.overflow_out;
        obs[2].nd  = 4'(if2.num_digits_out);
        for (int i = 0; i < 4; i++) begin
            obs[0].dg[i*4 +: 4] = if0.digits_out[i];
            obs[1].dg[i*4 +: 4] = if1.digits_out[i];
        end
        for (int i = 0; i < 3; i++) obs[2].dg[i*4 +: 4] = if2.digits_out[i];
        irdy[0] = if0.in_ready;
        irdy[1] = if1.in_ready;
        irdy[2] = if2.in_ready;
    end

    // Decimal reference: what the display should show for value v.
    function automatic obs_t model(int v, bit b, int sgn, int d);
        obs_t r;
        int mag, lim, n, t, p;
        r = '0;
        r.vld = 1'b1;
        r.sg  = (sgn != 0) && (v >= (1 << (W - 1)));
        mag   = r.sg ? (1 << W) - v : v;
        lim = 1;
        for (int i = 0; i < d; i++) lim *= 10;
        if (mag >= lim) begin
            r.ov = 1'b1;
            r.nd = 4'(d);
            for (int i = 0; i < d; i++) r.dg[i*4 +: 4] = 4'd9;
        end else begin
            n = 1; t = mag;
            while (t >= 10) begin t /= 10; n++; end
            r.nd = 4'(n);
            p = 1;
            for (int i = 0; i < d; i++) begin
                r.dg[i*4 +: 4] = (b && i >= n) ? 4'hF : 4'((mag / p) % 10);
                p *= 10;
            end
        end
        return r;
    endfunction

    function automatic obs_t mk(logic [15:0] dg, bit sg, bit ov, int nd);
        return {1'b1, dg, sg, ov, 4'(nd)};
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h want %h", name, k, act, exp);
        end
    endtask

    // Consumer: random or always-ready backpressure.
    always @(posedge clk) begin
        #1;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard and protocol checks, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("in_ready", k, 32'(irdy[k]), 32'(!rst && !(obs[k].vld && !out_ready)));
            if (rst) begin
                q[k].delete();
            end else begin
                if (prev_stall[k]) chk("stall_hold", k, 32'(obs[k]), 32'(prev_obs[k]));
                if (obs[k].vld && out_ready) begin
                    if (q[k].size() == 0) begin
                        chk("unexpected_out", k, 32'(obs[k]), 32'(0));
                    end else begin
                        in_t e;
                        e = q[k].pop_front();
                        chk("result", k, 32'(obs[k]), 32'(model(int'(e.v), e.b, SG[k], DG[k])));
                    end
                end
                if (in_valid && irdy[k]) q[k].push_back({data_in, blank_en});
            end
            prev_obs[k]   = obs[k];
            prev_stall[k] = !rst && obs[k].vld && !out_ready;
        end
    end

    task automatic push(input int v, input bit b);
        int t;
        t = 0;
        in_valid = 1'b1; data_in = W'(v); blank_en = b;
        @(negedge clk);
        while (!irdy[0] && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) chk("push_timeout", 0, 32'(1), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        rnd_mode = 1'b0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 2000) chk("drain_timeout", 0, 32'(1), 32'(0));
        @(posedge clk); #1;
    endtask

    task automatic directed(input int v, input bit b, input obs_t e0, input obs_t e1, input obs_t e2);
        int cnt;
        cnt = 0;
        drain();
        push(v, b);
        while (cnt < 100) begin
            @(posedge clk); #1; cnt++;
            if (obs[0].vld) break;
        end
        chk("latency", 0, 32'(cnt), 32'(13));
        chk("direct", 0, 32'(obs[0]), 32'(e0));
        chk("direct", 1, 32'(obs[1]), 32'(e1));
        chk("direct", 2, 32'(obs[2]), 32'(e2));
    endtask

    initial begin
        chk("model_pin", 0, 32'(model(4095, 1'b0, 0, 4)), 32'(mk(16'h4095, 0, 0, 4)));
        chk("model_pin", 1, 32'(model(2048, 1'b0, 1, 4)), 32'(mk(16'h2048, 1, 0, 4)));
        chk("model_pin", 2, 32'(model(7, 1'b1, 0, 3)), 32'(mk(16'h0FF7, 0, 0, 1)));

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_out", k, 32'(obs[k]), 32'(0));
            chk("reset_ready", k, 32'(irdy[k]), 32'(0));
        end
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 0, 32'(irdy[0]), 32'(1));

        directed(4095,   1'b0, mk(16'h4095, 0, 0, 4), mk(16'h0001, 1, 0, 1), mk(16'h0999, 0, 1, 3));
        directed(0,      1'b1, mk(16'hFFF0, 0, 0, 1), mk(16'hFFF0, 0, 0, 1), mk(16'h0FF0, 0, 0, 1));
        directed(7,      1'b1, mk(16'hFFF7, 0, 0, 1), mk(16'hFFF7, 0, 0, 1), mk(16'h0FF7, 0, 0, 1));
        directed('h800,  1'b0, mk(16'h2048, 0, 0, 4), mk(16'h2048, 1, 0, 4), mk(16'h0999, 0, 1, 3));
        directed(1000,   1'b0, mk(16'h1000, 0, 0, 4), mk(16'h1000, 0, 0, 4), mk(16'h0999, 0, 1, 3));
        directed(999,    1'b0, mk(16'h0999, 0, 0, 3), mk(16'h0999, 0, 0, 3), mk(16'h0999, 0, 0, 3));

        // Back-to-back ramp under random backpressure.
        drain();
        rnd_mode = 1'b1;
        for (int v = 0; v <= 200; v++) push(v, 1'($urandom_range(0, 1)));
        drain();

        // Random values with input gaps.
        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end else begin
                push(int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
            end
        end
        drain();

        // Reset with samples in flight; nothing stale may emerge afterwards.
        for (int i = 0; i < 10; i++) push(500 + i, 1'b0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk("ready_in_rst", k, 32'(irdy[k]), 32'(0));
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) chk("rst_clear", k, 32'(obs[k]), 32'(0));
        rst = 1'b0;
        directed(123, 1'b0, mk(16'h0123, 0, 0, 3), mk(16'h0123, 0, 0, 3), mk(16'h0123, 0, 0, 3));
        repeat (20) @(posedge clk);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
